load_store_unit: RTL and testbench

- Initiator side of the byte-addressed, 64-bit little-endian data-memory port. The MEM pipeline stage issues one load or store at a time on a valid/ready request interface.
- Translates each request into memory-port cycles using Mem_Addr, Write_Data, MemWrite, MemRead and Read_Data.
- Handles sub-word loads with sign or zero extension. Handles sub-word stores by read-modify-write of the enclosing aligned doubleword.
- Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-addressed 64-bit little-endian data memory.
// Sub-word stores are done as a read-modify-write of the enclosing aligned doubleword.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  localparam int unsigned XLEN      = 64;
  localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ST_RD = 3'd2,
    ST_WR = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state;
  logic [2:0]        funct3_q;
  logic [2:0]        lane_q;
  logic [XLEN-1:0]   base_q;
  logic [XLEN-1:0]   wdata_q;

  logic [XLEN-1:0]   req_base_c;
  logic              req_bad_f3_c;
  logic              req_misaligned_c;
  logic              req_out_of_range_c;
  logic              req_err_c;

  // Request qualification at acceptance: illegal funct3, misalignment, range.
  always_comb begin
    req_base_c         = {req_addr[XLEN-1:3], 3'b000};
    req_bad_f3_c       = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
    req_misaligned_c   = 1'b0;
    case (req_funct3[1:0])
      2'd0:    req_misaligned_c = 1'b0;
      2'd1:    req_misaligned_c = req_addr[0];
      2'd2:    req_misaligned_c = |req_addr[1:0];
      default: req_misaligned_c = |req_addr[2:0];
    endcase
    req_out_of_range_c = (req_base_c + XLEN'(7)) >= MEM_LIMIT;
    req_err_c          = req_bad_f3_c | req_misaligned_c | req_out_of_range_c;
  end

  logic [5:0]        shamt_c;
  logic [XLEN-1:0]   shifted_c;
  logic              sign_c;
  logic [XLEN-1:0]   load_ext_c;
  logic [XLEN-1:0]   size_mask_c;
  logic [XLEN-1:0]   lane_mask_c;
  logic [XLEN-1:0]   store_merge_c;

  // Load alignment/extension and sub-word store merge, both against Read_Data.
  always_comb begin
    shamt_c     = {lane_q, 3'b000};
    shifted_c   = Read_Data >> shamt_c;
    sign_c      = ~funct3_q[2];
    load_ext_c  = shifted_c;
    size_mask_c = {XLEN{1'b1}};
    case (funct3_q[1:0])
      2'd0: begin
        load_ext_c  = {{56{sign_c & shifted_c[7]}}, shifted_c[7:0]};
        size_mask_c = XLEN'(64'h0000_0000_0000_00FF);
      end
      2'd1: begin
        load_ext_c  = {{48{sign_c & shifted_c[15]}}, shifted_c[15:0]};
        size_mask_c = XLEN'(64'h0000_0000_0000_FFFF);
      end
      2'd2: begin
        load_ext_c  = {{32{sign_c & shifted_c[31]}}, shifted_c[31:0]};
        size_mask_c = XLEN'(64'h0000_0000_FFFF_FFFF);
      end
      default: begin
        load_ext_c  = shifted_c;
        size_mask_c = {XLEN{1'b1}};
      end
    endcase
    lane_mask_c   = size_mask_c << shamt_c;
    store_merge_c = (Read_Data & ~lane_mask_c) | ((wdata_q & size_mask_c) << shamt_c);
  end

  // Control FSM; every output is registered from the state being entered.
  // Write_Data holds the merged doubleword, so it doubles as the merge register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      funct3_q   <= 3'd0;
      lane_q     <= 3'd0;
      base_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      Mem_Addr   <= '0;
      Write_Data <= '0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
    end else begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      Mem_Addr   <= '0;
      Write_Data <= '0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            funct3_q <= req_funct3;
            lane_q   <= req_addr[2:0];
            base_q   <= req_base_c;
            wdata_q  <= req_wdata;
            if (req_err_c) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_write) begin
              state    <= LOAD;
              MemRead  <= 1'b1;
              Mem_Addr <= req_base_c;
            end else if (req_funct3[1:0] == 2'd3) begin
              state      <= ST_WR;
              MemWrite   <= 1'b1;
              Mem_Addr   <= req_base_c;
              Write_Data <= req_wdata;
            end else begin
              state    <= ST_RD;
              MemRead  <= 1'b1;
              Mem_Addr <= req_base_c;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= load_ext_c;
        end
        ST_RD: begin
          state      <= ST_WR;
          MemWrite   <= 1'b1;
          Mem_Addr   <= base_q;
          Write_Data <= store_merge_c;
        end
        ST_WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, byte-level reference model,
// one negedge compare process, directed cases plus randomized traffic.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemWrite(MemWrite),
    .MemRead(MemRead), .Read_Data(Read_Data)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT
  logic [7:0] mem [MEM_BYTES];

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
    mem[0] = 8'd3; mem[8] = 8'd1; mem[16] = 8'd4; mem[24] = 8'd2;
    forever begin
      @(posedge clk);
      if (MemWrite && Mem_Addr < 64'(MEM_BYTES))
        for (int i = 0; i < 8; i++) mem[int'(Mem_Addr[7:0]) + i] <= Write_Data[8*i +: 8];
    end
  end

  always_comb begin
    Read_Data = '0;
    if (Mem_Addr < 64'(MEM_BYTES))
      for (int i = 0; i < 8; i++) Read_Data[8*i +: 8] = mem[int'(Mem_Addr[7:0]) + i];
  end

  // Reference model
  typedef struct packed {
    logic        err;
    logic [3:0]  lat;
    logic        is_load;
    logic        is_store;
    logic [63:0] base;
    logic [63:0] rdata;
    logic [63:0] dw;
    logic        lit_en;
    logic [63:0] lit;
  } exp_t;

  logic [7:0] ref_mem [MEM_BYTES];

  function automatic exp_t model(logic w, logic [2:0] f3, logic [63:0] a, logic [63:0] wd);
    exp_t e;
    int size;
    logic [63:0] val;
    e = '0;
    size = 1 << f3[1:0];
    e.base = a & ~64'd7;
    e.err = (w ? (f3 >= 3'd4) : (f3 == 3'd7)) || ((a % 64'(size)) != 64'd0) ||
            ((e.base + 64'd7) >= 64'(MEM_BYTES));
    if (e.err) begin
      e.lat = 4'd1;
    end else if (!w) begin
      e.is_load = 1'b1;
      e.lat = 4'd2;
      val = '0;
      for (int i = 0; i < size; i++) val = val | (64'(ref_mem[int'(a[7:0]) + i]) << (8*i));
      if (f3 < 3'd4 && size < 8 && val[8*size-1]) val = val | ~((64'd1 << (8*size)) - 64'd1);
      e.rdata = val;
    end else begin
      e.is_store = 1'b1;
      e.lat = (size == 8) ? 4'd2 : 4'd3;
      for (int j = 0; j < 8; j++) e.dw[8*j +: 8] = ref_mem[int'(e.base[7:0]) + j];
      for (int i = 0; i < size; i++) e.dw[8*(int'(a[2:0]) + i) +: 8] = wd[8*i +: 8];
    end
    return e;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  int tmo_cnt = 0;
  logic        want_lit = 1'b0;
  logic [63:0] lit_val = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every cycle
  initial begin
    exp_t cur, nxt;
    logic active, pend, was_active;
    logic exp_rv, exp_mr, exp_mw;
    int k, tmo_seen;
    active = 0; pend = 0; k = 0; tmo_seen = 0;
    cur = '0; nxt = '0;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'd3; ref_mem[8] = 8'd1; ref_mem[16] = 8'd4; ref_mem[24] = 8'd2;
    forever begin
      @(negedge clk);
      chk("accept_timeout", 64'(tmo_cnt), 64'(tmo_seen));
      tmo_seen = tmo_cnt;
      if (reset) begin
        active = 0; pend = 0;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_MemWrite", 64'(MemWrite), 64'd0);
        chk("rst_MemRead", 64'(MemRead), 64'd0);
        chk("rst_Mem_Addr", Mem_Addr, 64'd0);
        continue;
      end
      if (pend) begin cur = nxt; active = 1; k = 0; pend = 0; end
      was_active = active;
      if (active) k++;
      exp_rv = active && (k == int'(cur.lat));
      exp_mr = active && (k == 1) && (cur.is_load || (cur.is_store && cur.lat == 4'd3));
      exp_mw = active && cur.is_store && (k == int'(cur.lat) - 1);
      chk("req_ready", 64'(req_ready), 64'(!was_active));
      chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
      chk("resp_err", 64'(resp_err), 64'(exp_rv && cur.err));
      chk("resp_rdata", resp_rdata, exp_rv ? cur.rdata : 64'd0);
      chk("MemRead", 64'(MemRead), 64'(exp_mr));
      chk("MemWrite", 64'(MemWrite), 64'(exp_mw));
      chk("Mem_Addr", Mem_Addr, (exp_mr || exp_mw) ? cur.base : 64'd0);
      if (exp_mw) chk("Write_Data", Write_Data, cur.dw);
      if (exp_rv && cur.lit_en) chk("literal_rdata", resp_rdata, cur.lit);
      if (exp_rv) begin
        if (cur.is_store)
          for (int j = 0; j < 8; j++) ref_mem[int'(cur.base[7:0]) + j] = cur.dw[8*j +: 8];
        active = 0;
      end
      if (!was_active && req_valid) begin
        nxt = model(req_write, req_funct3, req_addr, req_wdata);
        nxt.lit_en = want_lit;
        nxt.lit = lit_val;
        pend = 1;
      end
    end
  end

  task automatic issue(logic w, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                       logic le, logic [63:0] lv, logic keep);
    bit ok;
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    want_lit = le; lit_val = lv; req_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) tmo_cnt++;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) tmo_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic ld(logic [2:0] f3, logic [63:0] a, logic [63:0] lv);
    issue(1'b0, f3, a, 64'd0, 1'b1, lv, 1'b0);
    wait_idle();
  endtask

  task automatic st(logic [2:0] f3, logic [63:0] a, logic [63:0] wd);
    issue(1'b1, f3, a, wd, 1'b1, 64'd0, 1'b0);
    wait_idle();
  endtask

  initial begin
    logic w, keep;
    logic [2:0] f3;
    logic [63:0] a, wd;
    int r;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    ld(3'b000, 64'd0, 64'h3);
    st(3'b000, 64'd9, 64'hFF);
    ld(3'b000, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    ld(3'b100, 64'd9, 64'hFF);
    ld(3'b011, 64'd8, 64'hFF01);
    st(3'b011, 64'd16, 64'h8877_6655_4433_2211);
    ld(3'b010, 64'd20, 64'hFFFF_FFFF_8877_6655);
    ld(3'b110, 64'd20, 64'h0000_0000_8877_6655);
    ld(3'b001, 64'd22, 64'hFFFF_FFFF_FFFF_8877);
    ld(3'b101, 64'd16, 64'h2211);

    ld(3'b001, 64'd1, 64'd0);
    st(3'b010, 64'd6, 64'h1234);
    st(3'b011, 64'd256, 64'h55);
    ld(3'b111, 64'd0, 64'd0);

    issue(1'b0, 3'b010, 64'd20, 64'd0, 1'b1, 64'hFFFF_FFFF_8877_6655, 1'b1);
    issue(1'b0, 3'b010, 64'd16, 64'd0, 1'b1, 64'h4433_2211, 1'b0);
    wait_idle();

    // Reset lands inside ST_WR of a read-modify-write store
    issue(1'b1, 3'b001, 64'd2, 64'hBEEF, 1'b0, 64'd0, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    ld(3'b011, 64'd0, 64'h3);

    keep = 1'b0;
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (w && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
      r = $urandom_range(0, 9);
      if (r == 0)      a = {$urandom, $urandom};
      else if (r == 1) a = 64'($urandom_range(240, 270));
      else begin
        a = 64'($urandom_range(0, 255));
        if (r < 8) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      end
      wd = {$urandom, $urandom};
      keep = ($urandom_range(0, 3) == 0);
      issue(w, f3, a, wd, 1'b0, 64'd0, keep);
      if (!keep) wait_idle();
    end
    req_valid = 1'b0;
    wait_idle();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
